nes_clk_sched: RTL

- Clock-enable scheduler for the NES core, clocked by the 21.428 MHz PPU master clock from the system PLL.
- Replaces the separate PLL-divided PPU and 6502 clocks with phase-locked single-cycle enables: `ppu_ce` at ÷4 and `cpu_ce` at ÷12, so the CPU:PPU ratio is exactly 1:3.
- Sequences a startup reset hold and provides run/pause/single-step control for debug.
- Pause and step always land on CPU-cycle (frame) boundaries.

---
 rtl/nes_clk_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/nes_clk_sched.sv
// Master-clock enable scheduler: phase-locked PPU/CPU clock enables, startup reset hold,
// and run/pause/single-step control. Optional cpu_cycles counter via NES_CLK_SCHED_CYCLE_COUNT_EN.
module nes_clk_sched #(
    parameter int unsigned PPU_DIV        = 4,
    parameter int unsigned CPU_DIV        = 12,
    parameter int unsigned CPU_PHASE      = 0,
    parameter int unsigned STARTUP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_req,
    input  logic        step_req,
    output logic        ppu_ce,
    output logic        cpu_ce,
    output logic        sys_rst_n,
    output logic        running,
`ifdef NES_CLK_SCHED_CYCLE_COUNT_EN
    output logic [31:0] cpu_cycles,
`endif
    output logic        step_done
);

    localparam int unsigned CNT_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int unsigned SU_W  = $clog2(STARTUP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPU_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PHASE = CNT_W'(CPU_PHASE);
    localparam logic [SU_W-1:0]  SU_LAST   = SU_W'(STARTUP_CYCLES - 1);

    typedef enum logic [1:0] {StHold, StRun, StPaused, StStep} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SU_W-1:0]  startup_q, startup_d;
    logic             ppu_ce_q, ppu_ce_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             running_q, running_d;
    logic             step_done_q, step_done_d;
    logic             frame_end;

    assign frame_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        startup_d   = startup_q;
        sys_rst_n_d = sys_rst_n_q;
        step_done_d = 1'b0;
        unique case (state_q)
            StHold: begin
                startup_d = startup_q + 1'b1;
                if (startup_q == SU_LAST) begin
                    sys_rst_n_d = 1'b1;
                    state_d     = run_req ? StRun : StPaused;
                end
            end
            StRun: begin
                cnt_d = frame_end ? '0 : cnt_q + 1'b1;
                // A pending pause is cancelled by any later run_req=1, so only the
                // boundary sample decides whether this frame is the last one.
                if (frame_end && !run_req) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (run_req) begin
                    state_d = StRun;
                end else if (step_req) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                cnt_d = frame_end ? '0 : cnt_q + 1'b1;
                if (frame_end) begin
                    step_done_d = 1'b1;
                    state_d     = run_req ? StRun : StPaused;
                end
            end
            default: state_d = StHold;
        endcase

        // Enables are decoded from the next state/count so they align with cnt_q next cycle.
        running_d = (state_d == StRun) || (state_d == StStep);
        ppu_ce_d  = running_d && ((32'(cnt_d) % PPU_DIV) == 32'd0);
        cpu_ce_d  = running_d && (cnt_d == CNT_PHASE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            startup_q   <= '0;
            ppu_ce_q    <= 1'b0;
            cpu_ce_q    <= 1'b0;
            sys_rst_n_q <= 1'b0;
            running_q   <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            startup_q   <= startup_d;
            ppu_ce_q    <= ppu_ce_d;
            cpu_ce_q    <= cpu_ce_d;
            sys_rst_n_q <= sys_rst_n_d;
            running_q   <= running_d;
            step_done_q <= step_done_d;
        end
    end

    assign ppu_ce    = ppu_ce_q;
    assign cpu_ce    = cpu_ce_q;
    assign sys_rst_n = sys_rst_n_q;
    assign running   = running_q;
    assign step_done = step_done_q;

`ifdef NES_CLK_SCHED_CYCLE_COUNT_EN
    logic [31:0] cpu_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_cycles_q <= '0;
        end else if (!sys_rst_n_q) begin
            cpu_cycles_q <= '0;
        end else if (cpu_ce_q) begin
            cpu_cycles_q <= cpu_cycles_q + 32'd1;
        end
    end

    assign cpu_cycles = cpu_cycles_q;
`endif

endmodule
